program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 98 +++++++++
 tb/tb_program_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program counter sequencer with a small return-address stack for call/ret.
// pm_addr is the zero-latency fetch address; pc/stack state update on each rising clk.
module program_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       sync_reset_n,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic       r_eq_0,
    input  logic       call,
    input  logic       ret,
    input  logic       hold,
    input  logic [7:0] jmp_addr,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [7:0] from_PS,
    output logic [2:0] stack_ptr,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [7:0]       pc_q, pc_d;
    logic [2:0]       stack_ptr_q, stack_ptr_d;
    logic             stack_err_q, stack_err_d;
    logic [7:0]       stack_q [STACK_DEPTH];
    logic [7:0]       stack_d [STACK_DEPTH];
    logic [7:0]       pc_inc;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic             is_full;
    logic             is_empty;

    assign pc_inc   = pc_q + 8'd1;
    assign is_full  = (stack_ptr_q == 3'(STACK_DEPTH));
    assign is_empty = (stack_ptr_q == 3'd0);
    // Indices are only used when the pointer is in range (not empty / not full).
    assign top_idx  = IDX_W'(stack_ptr_q - 3'd1);
    assign push_idx = IDX_W'(stack_ptr_q);

    always_comb begin
        pm_addr     = pc_inc;
        stack_ptr_d = stack_ptr_q;
        stack_err_d = stack_err_q;
        stack_d     = stack_q;
        if (!sync_reset_n) begin
            pm_addr = 8'h00;
        end else if (hold) begin
            pm_addr = pc_q;
        end else if (ret) begin
            if (is_empty) begin
                stack_err_d = 1'b1;
            end else begin
                pm_addr     = stack_q[top_idx];
                stack_ptr_d = stack_ptr_q - 3'd1;
            end
        end else if (call) begin
            pm_addr = jmp_addr;
            if (is_full) begin
                stack_err_d = 1'b1;
            end else begin
                stack_d[push_idx] = pc_inc;
                stack_ptr_d       = stack_ptr_q + 3'd1;
            end
        end else if (jmp || (jmp_nz && !r_eq_0)) begin
            pm_addr = jmp_addr;
        end
        pc_d = pm_addr;
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            pc_q        <= 8'h00;
            stack_ptr_q <= 3'd0;
            stack_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            stack_ptr_q <= stack_ptr_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Entries carry no reset; stack_ptr alone decides which ones are meaningful.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc          = pc_q;
    assign from_PS     = pc_q;
    assign stack_ptr   = stack_ptr_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a reference model pushes expected state per cycle,
// popped and compared after each rising edge, plus directed constant checks.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset_n, jmp, jmp_nz, r_eq_0, call, ret, hold;
    logic [7:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic [2:0] stack_ptr;
    logic       stack_full, stack_empty, stack_err;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .jmp(jmp), .jmp_nz(jmp_nz),
        .r_eq_0(r_eq_0), .call(call), .ret(ret), .hold(hold), .jmp_addr(jmp_addr),
        .pm_addr(pm_addr), .pc(pc), .from_PS(from_PS), .stack_ptr(stack_ptr),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] ptr;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] m_pc;
    logic [7:0] m_stk [4];
    int         m_ptr;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic step(input logic rstn, input logic h, input logic c, input logic r,
                        input logic j, input logic jnz, input logic req0, input logic [7:0] addr);
        logic [7:0] pm;
        exp_t       e;
        @(negedge clk);
        sync_reset_n = rstn; hold = h; call = c; ret = r;
        jmp = j; jmp_nz = jnz; r_eq_0 = req0; jmp_addr = addr;
        #1;
        if (!rstn) begin
            pm = 8'h00; m_ptr = 0; m_err = 1'b0;
        end else if (h) begin
            pm = m_pc;
        end else if (r) begin
            if (m_ptr == 0) begin
                pm = m_pc + 8'd1; m_err = 1'b1;
            end else begin
                m_ptr--; pm = m_stk[m_ptr];
            end
        end else if (c) begin
            pm = addr;
            if (m_ptr == 4) m_err = 1'b1;
            else begin
                m_stk[m_ptr] = m_pc + 8'd1; m_ptr++;
            end
        end else if (j || (jnz && !req0)) begin
            pm = addr;
        end else begin
            pm = m_pc + 8'd1;
        end
        check("pm_addr", pm_addr, pm);
        m_pc = pm;
        e = '{pc: m_pc, ptr: 3'(m_ptr), err: m_err};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc", pc, e.pc);
            check("from_PS", from_PS, e.pc);
            check("stack_ptr", stack_ptr, e.ptr);
            check("stack_err", stack_err, e.err);
            check("stack_full", stack_full, e.ptr == 3'd4);
            check("stack_empty", stack_empty, e.ptr == 3'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask
    task automatic do_rst();
        step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask
    task automatic do_jmp(input logic [7:0] a);
        step(1, 0, 0, 0, 1, 0, 0, a);
    endtask
    task automatic do_call(input logic [7:0] a);
        step(1, 0, 1, 0, 0, 0, 0, a);
    endtask
    task automatic do_ret();
        step(1, 0, 0, 1, 0, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] ret_exp [4];
        ret_exp = '{8'h41, 8'h31, 8'h21, 8'h07};
        sync_reset_n = 1'b0; hold = 1'b0; call = 1'b0; ret = 1'b0;
        jmp = 1'b0; jmp_nz = 1'b0; r_eq_0 = 1'b0; jmp_addr = 8'h00;
        m_pc = 8'h00; m_ptr = 0; m_err = 1'b0;

        // Reset with every control active: pm_addr must still be 00.
        step(0, 1, 1, 1, 1, 1, 0, 8'hAA);
        do_rst();
        check("rst_pc", pc, 8'h00);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_err", stack_err, 1'b0);

        idle(1);
        check("first_inc", pc, 8'h01);
        idle(299);
        check("wrap_pc", pc, 8'h2C);
        check("wrap_err", stack_err, 1'b0);

        do_jmp(8'h10);
        step(1, 0, 0, 0, 0, 1, 1, 8'h40);
        check("jnz_not_taken", pc, 8'h11);
        do_jmp(8'h10);
        step(1, 0, 0, 0, 0, 1, 0, 8'h40);
        check("jnz_taken", pc, 8'h40);

        do_jmp(8'h05);
        do_call(8'h80);
        check("call_pc", pc, 8'h80);
        check("call_ptr", stack_ptr, 3'd1);
        idle(3);
        check("pre_ret_pc", pc, 8'h83);
        do_ret();
        check("ret_pc", pc, 8'h06);
        check("ret_empty", stack_empty, 1'b1);

        do_call(8'h20); do_call(8'h30); do_call(8'h40); do_call(8'h50);
        check("full_after_4", stack_full, 1'b1);
        check("no_err_4", stack_err, 1'b0);
        do_call(8'h60);
        check("overflow_err", stack_err, 1'b1);
        check("overflow_ptr", stack_ptr, 3'd4);
        check("overflow_pc", pc, 8'h60);
        for (int i = 0; i < 4; i++) begin
            do_ret();
            check("nested_ret", pc, ret_exp[i]);
        end

        do_rst();
        do_jmp(8'h22);
        do_ret();
        check("underflow_pc", pc, 8'h23);
        check("underflow_err", stack_err, 1'b1);
        idle(5);
        check("err_sticky", stack_err, 1'b1);
        do_rst();
        check("err_cleared", stack_err, 1'b0);

        do_call(8'h90);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 0, 8'hA0);
        check("hold_pc", pc, 8'h90);
        check("hold_ptr", stack_ptr, 3'd1);
        step(0, 0, 1, 0, 0, 0, 0, 8'hB0);
        check("rst_call_pc", pc, 8'h00);
        check("rst_call_ptr", stack_ptr, 3'd0);

        // Random mix against the model, including reset, hold and call/ret collisions.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
